// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator with configurable sync polarity,
// display-enable, pixel coordinates, line/frame strobes, frame counter and output pipeline delay.
module vga_timing_gen #(
   parameter int H_DISPLAY  = 640,
   parameter int H_BACK     = 48,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int V_DISPLAY  = 480,
   parameter int V_BACK     = 33,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter bit H_POL      = 1'b0,
   parameter bit V_POL      = 1'b0,
   parameter int CNT_W      = 11,
   parameter int PIPE_DELAY = 2
) (
   input  logic             vga_clk,
   input  logic             reset,
   input  logic             enable,
   output logic             hsync,
   output logic             vsync,
   output logic             display_on,
   output logic [CNT_W-1:0] pixel_x,
   output logic [CNT_W-1:0] pixel_y,
   output logic             line_start,
   output logic             frame_start,
   output logic [15:0]      frame_count
);
   localparam int H_TOTAL = H_SYNC + H_BACK + H_DISPLAY + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_DISPLAY + V_FRONT;
   localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
   localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
   localparam logic [CNT_W-1:0] H_ACT_BEG  = CNT_W'(H_SYNC + H_BACK);
   localparam logic [CNT_W-1:0] V_ACT_BEG  = CNT_W'(V_SYNC + V_BACK);
   localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_SYNC + H_BACK + H_DISPLAY);
   localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_SYNC + V_BACK + V_DISPLAY);

   typedef struct packed {
      logic             hs;
      logic             vs;
      logic             de;
      logic [CNT_W-1:0] px;
      logic [CNT_W-1:0] py;
      logic             ls;
      logic             fs;
      logic [15:0]      fc;
   } vid_t;

   // Idle output word: syncs inactive, everything else zero.
   localparam vid_t RST_VAL = '{hs: !H_POL, vs: !V_POL, de: 1'b0, px: {CNT_W{1'b0}},
                                py: {CNT_W{1'b0}}, ls: 1'b0, fs: 1'b0, fc: 16'd0};

   logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic [15:0]      frame_cnt_q, frame_cnt_d;
   logic             h_wrap, v_wrap, h_act, v_act;
   vid_t             stage_d;
   vid_t             stage_q [PIPE_DELAY+1];

   always_comb begin
      h_wrap      = h_cnt_q == H_LAST;
      v_wrap      = v_cnt_q == V_LAST;
      h_cnt_d     = h_wrap ? '0 : h_cnt_q + 1'b1;
      v_cnt_d     = h_wrap ? (v_wrap ? '0 : v_cnt_q + 1'b1) : v_cnt_q;
      frame_cnt_d = frame_cnt_q + {15'd0, h_wrap & v_wrap};
      h_act       = (h_cnt_q >= H_ACT_BEG) && (h_cnt_q < H_ACT_END);
      v_act       = (v_cnt_q >= V_ACT_BEG) && (v_cnt_q < V_ACT_END);
      stage_d.hs  = (h_cnt_q < H_SYNC_END) ? H_POL : !H_POL;
      stage_d.vs  = (v_cnt_q < V_SYNC_END) ? V_POL : !V_POL;
      stage_d.de  = h_act && v_act;
      stage_d.px  = (h_act && v_act) ? h_cnt_q - H_ACT_BEG : '0;
      stage_d.py  = (h_act && v_act) ? v_cnt_q - V_ACT_BEG : '0;
      stage_d.ls  = h_cnt_q == '0;
      stage_d.fs  = (h_cnt_q == '0) && (v_cnt_q == '0);
      stage_d.fc  = frame_cnt_q;
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         frame_cnt_q <= '0;
      end else if (enable) begin
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   always_ff @(posedge vga_clk) begin
      if (reset) stage_q[0] <= RST_VAL;
      else if (enable) stage_q[0] <= stage_d;
   end

   // Delay stages share the enable so the whole word stays aligned through stalls.
   for (genvar g = 1; g <= PIPE_DELAY; g++) begin : g_pipe
      always_ff @(posedge vga_clk) begin
         if (reset) stage_q[g] <= RST_VAL;
         else if (enable) stage_q[g] <= stage_q[g-1];
      end
   end

   assign {hsync, vsync, display_on, pixel_x, pixel_y, line_start, frame_start, frame_count} =
          stage_q[PIPE_DELAY];
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: four instances (default, inverted polarity, small mid-size, tiny) driven by
// shared stimulus and checked against an arithmetic raster model.
module tb_vga_timing_gen;
   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        de;
      logic [10:0] px;
      logic [10:0] py;
      logic        ls;
      logic        fs;
      logic [15:0] fc;
   } o_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic enable = 1'b1;
   logic hs [4];
   logic vs [4];
   logic de [4];
   logic ls [4];
   logic fs [4];
   logic [10:0] px [4];
   logic [10:0] py [4];
   logic [15:0] fc [4];
   o_t got [4];
   int checks = 0;
   int errors = 0;
   longint n = 0;
   longint dep = -1;
   int HS [4] = '{96, 96, 5, 2};
   int HB [4] = '{48, 48, 3, 1};
   int HD [4] = '{640, 640, 20, 4};
   int HF [4] = '{16, 16, 2, 1};
   int VS [4] = '{2, 2, 3, 1};
   int VB [4] = '{33, 33, 2, 1};
   int VD [4] = '{480, 480, 12, 2};
   int VF [4] = '{10, 10, 1, 1};
   int HP [4] = '{0, 1, 1, 0};
   int VP [4] = '{0, 1, 0, 0};
   int PD [4] = '{2, 2, 5, 0};

   always #5 clk = ~clk;

   vga_timing_gen u_def (
      .vga_clk(clk), .reset(reset), .enable(enable), .hsync(hs[0]), .vsync(vs[0]),
      .display_on(de[0]), .pixel_x(px[0]), .pixel_y(py[0]), .line_start(ls[0]),
      .frame_start(fs[0]), .frame_count(fc[0]));

   vga_timing_gen #(.H_POL(1'b1), .V_POL(1'b1)) u_pol (
      .vga_clk(clk), .reset(reset), .enable(enable), .hsync(hs[1]), .vsync(vs[1]),
      .display_on(de[1]), .pixel_x(px[1]), .pixel_y(py[1]), .line_start(ls[1]),
      .frame_start(fs[1]), .frame_count(fc[1]));

   vga_timing_gen #(.H_DISPLAY(20), .H_BACK(3), .H_FRONT(2), .H_SYNC(5), .V_DISPLAY(12),
                    .V_BACK(2), .V_FRONT(1), .V_SYNC(3), .H_POL(1'b1), .V_POL(1'b0),
                    .PIPE_DELAY(5)) u_mid (
      .vga_clk(clk), .reset(reset), .enable(enable), .hsync(hs[2]), .vsync(vs[2]),
      .display_on(de[2]), .pixel_x(px[2]), .pixel_y(py[2]), .line_start(ls[2]),
      .frame_start(fs[2]), .frame_count(fc[2]));

   vga_timing_gen #(.H_DISPLAY(4), .H_BACK(1), .H_FRONT(1), .H_SYNC(2), .V_DISPLAY(2),
                    .V_BACK(1), .V_FRONT(1), .V_SYNC(1), .PIPE_DELAY(0)) u_tiny (
      .vga_clk(clk), .reset(reset), .enable(enable), .hsync(hs[3]), .vsync(vs[3]),
      .display_on(de[3]), .pixel_x(px[3]), .pixel_y(py[3]), .line_start(ls[3]),
      .frame_start(fs[3]), .frame_count(fc[3]));

   always_comb
      for (int i = 0; i < 4; i++)
         got[i] = {hs[i], vs[i], de[i], px[i], py[i], ls[i], fs[i], fc[i]};

   // Expected outputs after cnt enabled edges since reset: the raster position of edge
   // cnt-(PD+1), or the idle word while the pipeline still holds reset contents.
   function automatic o_t model(int i, longint cnt);
      longint ht, vt, idx, h, v, f;
      o_t r;
      ht = HS[i] + HB[i] + HD[i] + HF[i];
      vt = VS[i] + VB[i] + VD[i] + VF[i];
      idx = cnt - PD[i] - 1;
      r = '0;
      if (idx < 0) begin
         r.hs = (HP[i] == 0);
         r.vs = (VP[i] == 0);
         return r;
      end
      h = idx % ht;
      v = (idx / ht) % vt;
      f = idx / (ht * vt);
      if (i == 3 && dep >= 0 && idx >= dep) f = f - dep / (ht * vt) + 65535;
      r.hs = (h < HS[i]) ? (HP[i] != 0) : (HP[i] == 0);
      r.vs = (v < VS[i]) ? (VP[i] != 0) : (VP[i] == 0);
      r.de = h >= HS[i] + HB[i] && h < HS[i] + HB[i] + HD[i] &&
             v >= VS[i] + VB[i] && v < VS[i] + VB[i] + VD[i];
      r.px = r.de ? 11'(h - HS[i] - HB[i]) : 11'd0;
      r.py = r.de ? 11'(v - VS[i] - VB[i]) : 11'd0;
      r.ls = (h == 0);
      r.fs = (h == 0 && v == 0);
      r.fc = 16'(f);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      n = reset ? 0 : n + (enable ? 1 : 0);
      if (reset) dep = -1;
      #1;
   endtask

   task automatic test_reset();
      o_t rv;
      reset = 1'b1;
      enable = 1'b1;
      repeat (3) tick();
      enable = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (got[i] !== model(i, n)) begin
            errors++;
            $display("FAIL reset_model dut%0d got=%h exp=%h", i, got[i], model(i, n));
         end
      end
      rv = '0;
      rv.hs = 1'b1;
      rv.vs = 1'b1;
      checks++;
      if (got[0] !== rv) begin
         errors++;
         $display("FAIL reset_default got=%h exp=%h", got[0], rv);
      end
      checks++;
      if (hs[1] !== 1'b0 || vs[1] !== 1'b0) begin
         errors++;
         $display("FAIL reset_pol_sync got=%b%b exp=00", hs[1], vs[1]);
      end
      reset = 1'b0;
      enable = 1'b1;
   endtask

   task automatic test_sync_timing();
      int falls[$];
      int hlow = 0, hhigh = 0, vlow = 0, last_ls = -1, last_fs = -1, ls_n = 0, fs_n = 0;
      logic prev = 1'b1;
      for (int k = 1; k <= 1700; k++) begin
         tick();
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== model(i, n)) begin
               errors++;
               $display("FAIL sync_model dut%0d n=%0d got=%h exp=%h", i, n, got[i], model(i, n));
            end
         end
         if (prev && !hs[0]) falls.push_back(k);
         prev = hs[0];
         if (k >= 3 && k < 803) begin
            if (hs[0]) hhigh++;
            else hlow++;
         end
         if (k >= 3 && k < 1603 && !vs[0]) vlow++;
         if (ls[3]) begin
            if (last_ls >= 0) begin
               checks++;
               if (k - last_ls != 8) begin
                  errors++;
                  $display("FAIL tiny_line_period got=%0d exp=8", k - last_ls);
               end
            end
            last_ls = k;
            ls_n++;
         end
         if (fs[3]) begin
            if (last_fs >= 0) begin
               checks++;
               if (k - last_fs != 40) begin
                  errors++;
                  $display("FAIL tiny_frame_period got=%0d exp=40", k - last_fs);
               end
            end
            last_fs = k;
            fs_n++;
         end
      end
      checks++;
      if (falls.size() != 3) begin
         errors++;
         $display("FAIL hsync_fall_count got=%0d exp=3", falls.size());
      end else if (falls[0] != 3 || falls[1] != 803 || falls[2] != 1603) begin
         errors++;
         $display("FAIL hsync_falls got=%0d,%0d,%0d exp=3,803,1603", falls[0], falls[1], falls[2]);
      end
      checks++;
      if (hlow != 96) begin errors++; $display("FAIL hsync_low got=%0d exp=96", hlow); end
      checks++;
      if (hhigh != 704) begin errors++; $display("FAIL hsync_high got=%0d exp=704", hhigh); end
      checks++;
      if (vlow != 1600) begin errors++; $display("FAIL vsync_low got=%0d exp=1600", vlow); end
      checks++;
      if (ls_n != 213 || fs_n != 43) begin
         errors++;
         $display("FAIL tiny_strobe_count got=%0d/%0d exp=213/43", ls_n, fs_n);
      end
   endtask

   task automatic test_active_window();
      int maxpx = 0, bad_seq = 0, bad_zero = 0;
      logic prev_de = 1'b1;
      logic [10:0] prevpx = 11'd0;
      while (n < 40000 && de[0] !== 1'b1) begin
         tick();
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== model(i, n)) begin
               errors++;
               $display("FAIL window_model dut%0d n=%0d got=%h exp=%h", i, n, got[i], model(i, n));
            end
         end
      end
      checks++;
      if (de[0] !== 1'b1 || n != 28147 || px[0] !== 11'd0 || py[0] !== 11'd0) begin
         errors++;
         $display("FAIL de_first got n=%0d de=%b x=%0d y=%0d exp n=28147 de=1 x=0 y=0",
                  n, de[0], px[0], py[0]);
      end
      for (int k = 0; k < 800; k++) begin
         tick();
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== model(i, n)) begin
               errors++;
               $display("FAIL line_model dut%0d n=%0d got=%h exp=%h", i, n, got[i], model(i, n));
            end
         end
         if (de[0]) begin
            if (prev_de && px[0] != prevpx + 11'd1) bad_seq++;
            if (int'(px[0]) > maxpx) maxpx = int'(px[0]);
         end else if (px[0] != 0 || py[0] != 0) bad_zero++;
         prev_de = de[0];
         prevpx = px[0];
      end
      checks++;
      if (maxpx != 639) begin errors++; $display("FAIL last_pixel_x got=%0d exp=639", maxpx); end
      checks++;
      if (bad_seq != 0 || bad_zero != 0) begin
         errors++;
         $display("FAIL pixel_seq got seq_err=%0d zero_err=%0d exp 0/0", bad_seq, bad_zero);
      end
      checks++;
      if (px[0] !== 11'd0 || py[0] !== 11'd1) begin
         errors++;
         $display("FAIL second_row got x=%0d y=%0d exp x=0 y=1", px[0], py[0]);
      end
   endtask

   task automatic test_mid_frame();
      int dec = 0, vlo = 0, hhi = 0, lsn = 0, fsn = 0, maxx = 0, maxy = 0, w = 0;
      while (w < 600 && fs[2] !== 1'b1) begin
         tick();
         w++;
      end
      for (int k = 0; k < 540; k++) begin
         if (de[2]) begin
            dec++;
            if (int'(px[2]) > maxx) maxx = int'(px[2]);
            if (int'(py[2]) > maxy) maxy = int'(py[2]);
         end
         if (!vs[2]) vlo++;
         if (hs[2]) hhi++;
         if (ls[2]) lsn++;
         if (fs[2]) fsn++;
         tick();
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== model(i, n)) begin
               errors++;
               $display("FAIL mid_model dut%0d n=%0d got=%h exp=%h", i, n, got[i], model(i, n));
            end
         end
      end
      checks++;
      if (dec != 240 || maxx != 19 || maxy != 11) begin
         errors++;
         $display("FAIL mid_de got cnt=%0d x=%0d y=%0d exp 240/19/11", dec, maxx, maxy);
      end
      checks++;
      if (vlo != 90 || hhi != 90) begin
         errors++;
         $display("FAIL mid_sync got v=%0d h=%0d exp 90/90", vlo, hhi);
      end
      checks++;
      if (lsn != 18 || fsn != 1 || fs[2] !== 1'b1) begin
         errors++;
         $display("FAIL mid_strobes got ls=%0d fs=%0d next=%b exp 18/1/1", lsn, fsn, fs[2]);
      end
   endtask

   task automatic test_enable_pause();
      o_t snap [4];
      int w = 0;
      while (w < 900 && n % 800 != 300) begin
         tick();
         w++;
      end
      checks++;
      if (n % 800 != 300) begin errors++; $display("FAIL pause_wait got=%0d exp=300", n % 800); end
      for (int i = 0; i < 4; i++) snap[i] = model(i, n);
      enable = 1'b0;
      repeat (10) begin
         tick();
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== snap[i]) begin
               errors++;
               $display("FAIL pause_frozen dut%0d got=%h exp=%h", i, got[i], snap[i]);
            end
         end
      end
      enable = 1'b1;
      repeat (200) begin
         tick();
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== model(i, n)) begin
               errors++;
               $display("FAIL pause_resume dut%0d n=%0d got=%h exp=%h", i, n, got[i], model(i, n));
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      int first [4] = '{-1, -1, -1, -1};
      int w = 0;
      o_t rv;
      while (w < 5000 && (n / 800) % 525 != 40) begin
         tick();
         w++;
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      rv = '0;
      rv.hs = 1'b1;
      rv.vs = 1'b1;
      checks++;
      if (got[0] !== rv) begin errors++; $display("FAIL midreset_def got=%h exp=%h", got[0], rv); end
      checks++;
      if (got[1] !== '0) begin errors++; $display("FAIL midreset_pol got=%h exp=0", got[1]); end
      checks++;
      if (fc[2] !== 16'd0 || fc[3] !== 16'd0 || hs[2] !== 1'b0 || vs[2] !== 1'b1) begin
         errors++;
         $display("FAIL midreset_small got fc=%h/%h hs=%b vs=%b exp 0/0/0/1", fc[2], fc[3], hs[2], vs[2]);
      end
      for (int k = 1; k <= 8; k++) begin
         tick();
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== model(i, n)) begin
               errors++;
               $display("FAIL midreset_model dut%0d n=%0d got=%h exp=%h", i, n, got[i], model(i, n));
            end
            if (fs[i] && first[i] < 0) first[i] = k;
         end
      end
      checks++;
      if (first[0] != 3 || first[1] != 3 || first[2] != 6 || first[3] != 1) begin
         errors++;
         $display("FAIL midreset_fs_latency got=%0d,%0d,%0d,%0d exp=3,3,6,1",
                  first[0], first[1], first[2], first[3]);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 3000; k++) begin
         enable = ($urandom_range(0, 3) != 0);
         reset = ($urandom_range(0, 399) == 0);
         tick();
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== model(i, n)) begin
               errors++;
               $display("FAIL random_model dut%0d n=%0d got=%h exp=%h", i, n, got[i], model(i, n));
            end
         end
      end
      reset = 1'b0;
      enable = 1'b1;
   endtask

   task automatic test_frame_wrap();
      int w = 0, bad = 0;
      while (w < 50 && n % 40 != 5) begin
         tick();
         w++;
      end
      force u_tiny.frame_cnt_q = 16'hFFFF;
      dep = n;
      tick();
      release u_tiny.frame_cnt_q;
      checks++;
      if (fc[3] !== 16'hFFFF) begin errors++; $display("FAIL wrap_forced got=%h exp=ffff", fc[3]); end
      w = 0;
      while (w < 45 && fs[3] !== 1'b1) begin
         tick();
         w++;
         if (!fs[3] && fc[3] !== 16'hFFFF) bad++;
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== model(i, n)) begin
               errors++;
               $display("FAIL wrap_model dut%0d n=%0d got=%h exp=%h", i, n, got[i], model(i, n));
            end
         end
      end
      checks++;
      if (fs[3] !== 1'b1 || fc[3] !== 16'h0000 || bad != 0) begin
         errors++;
         $display("FAIL wrap_zero got fs=%b fc=%h hold_err=%0d exp fs=1 fc=0000 0", fs[3], fc[3], bad);
      end
   endtask

   initial begin
      test_reset();
      test_sync_timing();
      test_active_window();
      test_mid_frame();
      test_enable_pause();
      test_mid_reset();
      test_random();
      test_frame_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
